// File: rtl/mux_stream_packer.sv
// mux_stream_packer: packs the serializer's 16-bit word stream into
// 32-bit beats with first/last tags, buffered by a small FIFO.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   din, sync           serializer word, start-of-frame strobe
//   out_data/valid/ready  beat stream {word 2k+1, word 2k}
//   out_first/out_last  beat holds words 0/1 or WORDS-2/WORDS-1
//   busy                frame capture in progress
//   overflow, frame_err sticky error flags
//   checksum(_valid)    only when CHECKSUM_EN is defined
//
// Optional feature macro: CHECKSUM_EN (per-frame 16-bit word sum).

module mux_stream_packer #(
   parameter int WORDS = 288,
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] din,
   input  logic        sync,
   output logic [31:0] out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_first,
   output logic        out_last,
   output logic        busy,
   output logic        overflow,
   output logic        frame_err
`ifdef CHECKSUM_EN
   ,
   output logic [15:0] checksum,
   output logic        checksum_valid
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam logic IDLE    = 1'b0;
   localparam logic CAPTURE = 1'b1;
   localparam logic [8:0] LAST_IDX = 9'(WORDS - 1);
   localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

   logic          state;
   logic [8:0]    idx;
   logic [15:0]   hold;
   logic [33:0]   mem [DEPTH];
   logic [PW-1:0] wptr;
   logic [PW-1:0] rptr;
   logic [PW:0]   cnt;

   logic        take;
   logic        push;
   logic        pop;
   logic        full;
   logic        empty;
   logic        push_ok;
   logic [33:0] beat;
   logic [33:0] head;

   always_comb begin
      take    = (state == CAPTURE) && !sync;
      push    = take && idx[0];
      beat    = {idx == LAST_IDX, idx == 9'd1, din, hold};
      full    = (cnt == FULL_CNT);
      empty   = (cnt == '0);
      pop     = !empty && out_ready;
      // a full FIFO still accepts when the head leaves the same cycle
      push_ok = push && (!full || pop);
      head    = mem[rptr];
   end

   assign out_valid = !empty;
   assign out_data  = empty ? 32'd0 : head[31:0];
   assign out_first = !empty && head[32];
   assign out_last  = !empty && head[33];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         idx       <= '0;
         hold      <= '0;
         busy      <= 1'b0;
         overflow  <= 1'b0;
         frame_err <= 1'b0;
         wptr      <= '0;
         rptr      <= '0;
         cnt       <= '0;
      end else begin
         // stays high one cycle past the final word
         busy <= sync || (state == CAPTURE);
         if (sync) begin
            if (state == CAPTURE)
               frame_err <= 1'b1;
            state <= CAPTURE;
            idx   <= 9'd1;
            hold  <= din;
         end else if (state == CAPTURE) begin
            if (!idx[0])
               hold <= din;
            if (idx == LAST_IDX) begin
               state <= IDLE;
               idx   <= '0;
            end else begin
               idx <= idx + 9'd1;
            end
         end
         if (push && full && !pop)
            overflow <= 1'b1;
         if (push_ok)
            wptr <= wptr + 1'b1;
         if (pop)
            rptr <= rptr + 1'b1;
         unique case (1'b1)
            (push_ok && !pop): cnt <= cnt + 1'b1;
            (pop && !push_ok): cnt <= cnt - 1'b1;
            default:           cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wptr] <= beat;
   end

`ifdef CHECKSUM_EN
   logic [15:0] acc;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc            <= '0;
         checksum       <= '0;
         checksum_valid <= 1'b0;
      end else begin
         checksum_valid <= 1'b0;
         if (sync) begin
            acc <= din;
         end else if (state == CAPTURE) begin
            acc <= acc + din;
            if (idx == LAST_IDX) begin
               checksum       <= acc + din;
               checksum_valid <= 1'b1;
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_mux_stream_packer.sv
// tb_mux_stream_packer: directed and random frames checked against a
// queue-based model of word capture, beat packing and FIFO.

module tb_mux_stream_packer;

   localparam int WORDS = 288;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] din;
   logic        sync;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        out_first;
   logic        out_last;
   logic        busy;
   logic        overflow;
   logic        frame_err;
`ifdef CHECKSUM_EN
   logic [15:0] checksum;
   logic        checksum_valid;
`endif

   mux_stream_packer #(.WORDS(WORDS), .DEPTH(DEPTH)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .din(din),
      .sync(sync),
      .out_data(out_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_first(out_first),
      .out_last(out_last),
      .busy(busy),
      .overflow(overflow),
      .frame_err(frame_err)
`ifdef CHECKSUM_EN
      ,
      .checksum(checksum),
      .checksum_valid(checksum_valid)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   bit          in_frame;
   logic [15:0] words[$];
   logic [33:0] q[$];
   bit          m_ovf;
   bit          m_ferr;
   bit          m_busy;
   logic [15:0] m_sum;
   logic [15:0] m_cs;
   bit          m_csv;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic model_update(input bit r, input bit s,
                               input logic [15:0] d, input bit rdy);
      bit          pop;
      logic [33:0] b;
      if (!r) begin
         q.delete();
         words.delete();
         in_frame = 0;
         m_ovf    = 0;
         m_ferr   = 0;
         m_busy   = 0;
         m_sum    = '0;
         m_cs     = '0;
         m_csv    = 0;
      end else begin
         pop    = (q.size() != 0) && rdy;
         m_busy = in_frame || s;
         m_csv  = 0;
         if (pop)
            void'(q.pop_front());
         if (s) begin
            if (in_frame)
               m_ferr = 1;
            words.delete();
            words.push_back(d);
            m_sum    = d;
            in_frame = 1;
         end else if (in_frame) begin
            words.push_back(d);
            m_sum = m_sum + d;
            if (words.size() % 2 == 0) begin
               b = {words.size() == WORDS, words.size() == 2,
                    d, words[words.size() - 2]};
               if (q.size() < DEPTH)
                  q.push_back(b);
               else
                  m_ovf = 1;
            end
            if (words.size() == WORDS) begin
               in_frame = 0;
               m_cs     = m_sum;
               m_csv    = 1;
            end
         end
      end
   endtask

   task automatic compare();
      check("out_valid", 32'(out_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
         check("out_data", out_data, q[0][31:0]);
         check("out_first", 32'(out_first), 32'(q[0][32]));
         check("out_last", 32'(out_last), 32'(q[0][33]));
      end
      check("busy", 32'(busy), 32'(m_busy));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("frame_err", 32'(frame_err), 32'(m_ferr));
`ifdef CHECKSUM_EN
      check("checksum", 32'(checksum), 32'(m_cs));
      check("checksum_valid", 32'(checksum_valid), 32'(m_csv));
`endif
   endtask

   task automatic cycle(input bit r, input bit s,
                        input logic [15:0] d, input bit rdy);
      rst_n     = r;
      sync      = s;
      din       = d;
      out_ready = rdy;
      model_update(r, s, d, rdy);
      @(negedge clk);
      compare();
   endtask

   task automatic do_reset();
      cycle(0, 0, 16'($urandom), 0);
      cycle(0, 0, 16'($urandom), 1);
   endtask

   task automatic idle(input int n, input int rmode);
      for (int i = 0; i < n; i++)
         cycle(1, 0, 16'($urandom),
               rmode == 0 ? 1'b1 : 1'($urandom_range(0, 1)));
   endtask

   // mode: 0 ready, 1 stalled 20 cycles, 2 50%, 3 75%, 4 ready from idx 9
   task automatic run_frame(input int mode, input int abort_at,
                            input int rst_at, input bit seq);
      int          total;
      logic [15:0] d;
      bit          s;
      bit          r;
      bit          rdy;
      bool_plain: begin end
      total = (abort_at >= 0) ? abort_at + WORDS : WORDS;
      for (int i = 0; i < total; i++) begin
         d = seq ? 16'(i + 1) : 16'($urandom);
         s = (i == 0) || (i == abort_at);
         r = (i != rst_at);
         case (mode)
            1:       rdy = (i >= 20);
            2:       rdy = 1'($urandom_range(0, 1));
            3:       rdy = ($urandom_range(0, 3) != 0);
            4:       rdy = (i >= 9);
            default: rdy = 1'b1;
         endcase
         cycle(r, s, d, rdy);
         if (seq && mode == 0 && rst_at < 0) begin
            if (i == 0)
               check("busy_start", 32'(busy), 32'd1);
            if (i == 1 && abort_at < 0) begin
               check("beat0_data", out_data, 32'h0002_0001);
               check("beat0_first", 32'(out_first), 32'd1);
            end
            if (i == WORDS - 1 && abort_at < 0) begin
               check("beatN_data", out_data, 32'h0120_011F);
               check("beatN_last", 32'(out_last), 32'd1);
`ifdef CHECKSUM_EN
               check("cs_value", 32'(checksum), 32'h0000_A290);
               check("cs_pulse", 32'(checksum_valid), 32'd1);
`endif
            end
            if (abort_at >= 0 && i == abort_at + 1) begin
               check("restart_data", out_data, 32'h0066_0065);
               check("restart_first", 32'(out_first), 32'd1);
               check("restart_ferr", 32'(frame_err), 32'd1);
            end
         end
         if (mode == 1 && seq && i == 19) begin
            check("stall_head", out_data, 32'h0002_0001);
            check("stall_ovf", 32'(overflow), 32'd1);
         end
         if (i == rst_at) begin
            check("rst_valid", 32'(out_valid), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
         end
      end
   endtask

   initial begin
      int ab;
      int rs;
      rst_n     = 1'b0;
      sync      = 1'b0;
      din       = '0;
      out_ready = 1'b0;
      do_reset();
      check("rst_data", out_data, 32'd0);
      check("rst_first", 32'(out_first), 32'd0);
      check("rst_last", 32'(out_last), 32'd0);
      idle(3, 0);

      run_frame(0, -1, -1, 1);
      idle(12, 0);
      check("clean_ovf", 32'(overflow), 32'd0);
      check("clean_ferr", 32'(frame_err), 32'd0);

      run_frame(1, -1, -1, 1);
      idle(12, 0);

      do_reset();
      run_frame(4, -1, -1, 1);
      idle(12, 0);
      check("nodrop_ovf", 32'(overflow), 32'd0);

      run_frame(0, 100, -1, 1);
      idle(12, 0);

      do_reset();
      run_frame(0, -1, 50, 1);
      idle(4, 0);
      run_frame(0, -1, -1, 1);
      idle(12, 0);
      check("post_rst_ferr", 32'(frame_err), 32'd0);

      for (int f = 0; f < 14; f++) begin
         ab = -1;
         rs = -1;
         if ($urandom_range(0, 3) == 0)
            ab = $urandom_range(3, WORDS - 3);
         else if ($urandom_range(0, 5) == 0)
            rs = $urandom_range(2, WORDS - 2);
         run_frame($urandom_range(0, 3), ab, rs, 0);
         idle($urandom_range(0, 10), 1);
         if ($urandom_range(0, 4) == 0)
            do_reset();
      end
      idle(12, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mux_stream_packer.md
# mux_stream_packer

Downstream stage of the 288-to-1 word serializer in the carry-save multiplier datapath. It captures the serializer's 16-bit word stream, one word per clock, and packs adjacent word pairs into 32-bit beats. The beats pass through a small FIFO to a valid/ready output. Frames are marked with first/last flags, and overflow and framing errors are flagged.

## Interface
- WORDS, 288: data words per frame; even, at most 511.
- DEPTH, 4: FIFO depth in 32-bit beats; power of two, at least 2.
- clk  in  1: sole clock, rising edge.
- rst_n  in  1: synchronous, active-low reset, sampled on the rising edge of clk.
- din  in  16: serializer output word; the serializer presents one new word per clock.
- sync  in  1: high for one cycle when din carries word 0 of a frame.
- out_data  out  32: packed beat; word 2k+1 in [31:16], word 2k in [15:0].
- out_valid  out  1: FIFO non-empty.
- out_ready  in  1: consumer accepts the beat when out_valid and out_ready are both high.
- out_first  out  1: current beat holds words 0/1.
- out_last  out  1: current beat holds words WORDS-2/WORDS-1.
- busy  out  1: a frame capture is in progress.
- overflow  out  1: sticky; a beat was dropped because the FIFO was full.
- frame_err  out  1: sticky; sync arrived while a frame was in progress.
- checksum  out  16: present only with CHECKSUM_EN.
- checksum_valid  out  1: present only with CHECKSUM_EN.

## Operation
- States:
  - IDLE: ignore din.
  - CAPTURE: word index idx runs 0..WORDS-1.
- IDLE to CAPTURE: sync=1.
  - din is word 0 on that cycle.
  - idx becomes 1 after the edge.
  - word 0 goes to the low-half holding register.
- In CAPTURE, one word is consumed per cycle; there are no stalls.
  - Even idx: load the holding register.
  - Odd idx: form the beat {din, hold}. Set first/last tag bits: first when idx=1, last when idx=WORDS-1. Push beat and tags into the FIFO.
- After word WORDS-1 is consumed, return to IDLE. Cycles after that carry no frame data (the serializer's idle/default words) and are ignored.
- sync in CAPTURE:
  - Set frame_err.
  - Discard the partially held word.
  - Restart at word 0 from the current din. The new frame's first beat is tagged first.
  - Beats already in the FIFO are kept.
  - The aborted frame never gets a last tag.
- FIFO:
  - DEPTH entries of 34 bits: data plus first/last tags.
  - Pointers wrap modulo DEPTH. An occupancy counter distinguishes full from empty.
  - Push while full, with no pop in the same cycle: the beat is dropped and overflow is set.
  - Push and pop in the same cycle while full: both happen, no drop.
  - Pop while empty: no effect.
- out_data, out_first and out_last come from the FIFO head. They are held stable while out_valid=1 and out_ready=0.
- overflow and frame_err clear only on reset.
- Reset values:
  - state IDLE, idx 0, FIFO empty.
  - out_valid 0, out_first 0, out_last 0, out_data 0.
  - busy 0, overflow 0, frame_err 0.
  - checksum 0, checksum_valid 0.
- Reset asserted mid-frame aborts the capture and empties the FIFO, with no error flag.

## Timing
- busy is high from the cycle after sync through the cycle after word WORDS-1 is consumed.
- Sync in cycle t, with out_ready held high:
  - words 0/1 are pushed at the end of cycle t+1.
  - out_valid is high in cycle t+2 (latency 2).
  - one beat is produced every 2 cycles, WORDS/2 beats per frame.
- The last beat is pushed at the end of cycle t+WORDS-1.
- With out_ready held low, the FIFO fills after DEPTH beats, i.e. at the end of cycle t+2·DEPTH-1. Every later push drops a beat.
- A consumer that accepts at least one beat every 2 cycles never causes overflow.

## Configuration
- CHECKSUM_EN defined:
  - A 16-bit accumulator sums every captured word modulo 2^16; it starts from din at sync.
  - When word WORDS-1 is consumed, the final sum is loaded into checksum, and checksum_valid pulses for 1 cycle, the cycle after consumption.
  - checksum holds its value until the next frame completes.
  - An aborted frame produces no pulse.
- CHECKSUM_EN undefined: the checksum and checksum_valid ports, the accumulator and the related logic are absent.

## Test plan
- Reset; sync with din = index+1 (values 1..288); out_ready=1. Expect:
  - 144 beats; beat 0 is 0x00020001 with first=1.
  - beat 143 is 0x0120011F with last=1.
  - first out_valid two cycles after sync; no flags set.
- Same frame with out_ready=0 for 20 cycles after sync, then 1. Expect:
  - exactly 4 beats retained, words 1..8, with beat 0 = 0x00020001.
  - overflow=1; later beats resume without corruption of FIFO entries.
- Second sync at idx=100 (word 101, din=0x0065). Expect:
  - frame_err=1.
  - next beat tagged first = {din at restart+1, din at restart}.
  - only one last beat observed.
- Full FIFO with out_ready=1 on the push cycle. Expect no drop and overflow=0.
- Reset held low on the cycle of idx=50. Expect out_valid=0 next cycle, busy=0, and a clean frame on the next sync.
- CHECKSUM_EN with din=1..288. Expect checksum=0xA290 (41616 mod 65536) and a checksum_valid pulse 1 cycle after word 288.
